// File: rtl/perf_counter_bank.sv
// perf_counter_bank: event counters plus a 64-bit cycle counter, read over the
// single-outstanding perf read bus with a fixed stall/ack sequence.
module perf_counter_bank #(
  parameter int unsigned NCOUNT      = 8,
  parameter int unsigned CW          = 32,
  parameter bit          ENABLE_PERF = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NCOUNT-1:0] i_events,
  input  logic              i_clear,
  input  logic              perf_stb,
  input  logic [7:0]        perf_addr,
  output logic              perf_stall,
  output logic              perf_ack,
  output logic [31:0]       perf_data
);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_ACK} state_t;

  localparam logic [31:0] ID_WORD = {16'h5043, 8'(NCOUNT), 8'(CW)};

  state_t        state_q, state_d;
  logic          accept;
  logic [CW-1:0] ev_cnt [NCOUNT];
  logic [63:0]   cyc_cnt;
  logic [31:0]   hi_shadow;
  logic [31:0]   rd_mux;
  logic [31:0]   snap_q;

  assign accept = perf_stb && (state_q == S_IDLE);

  generate
    if (ENABLE_PERF) begin : g_perf
      // Event counters: clear wins over a simultaneous event, wrap on overflow.
      always_ff @(posedge i_clk) begin
        for (int unsigned k = 0; k < NCOUNT; k++) begin
          if (i_reset || i_clear) ev_cnt[k] <= '0;
          else                    ev_cnt[k] <= ev_cnt[k] + CW'(i_events[k]);
        end
      end

      // Free-running 64-bit cycle counter.
      always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) cyc_cnt <= '0;
        else                    cyc_cnt <= cyc_cnt + 64'd1;
      end

      // Upper half latched alongside every low-half read so 0x41 is coherent.
      always_ff @(posedge i_clk) begin
        if (i_reset)                         hi_shadow <= '0;
        else if (accept && perf_addr == 8'h40) hi_shadow <= cyc_cnt[63:32];
      end
    end else begin : g_noperf
      // Counters removed; everything reads as zero.
      always_comb begin
        cyc_cnt   = '0;
        hi_shadow = '0;
        for (int unsigned k = 0; k < NCOUNT; k++) ev_cnt[k] = '0;
      end
    end
  endgenerate

  // Address decode of the live counter values.
  always_comb begin
    rd_mux = '0;
    if (ENABLE_PERF) begin
      for (int unsigned k = 0; k < NCOUNT; k++) begin
        if (perf_addr == 8'(k)) rd_mux = 32'(ev_cnt[k]);
      end
      case (perf_addr)
        8'h40:   rd_mux = cyc_cnt[31:0];
        8'h41:   rd_mux = hi_shadow;
        8'h42:   rd_mux = ID_WORD;
        default: ;
      endcase
    end
  end

  // Read data snapshot. The mux is sampled at the accept edge rather than a
  // cycle later so the returned value excludes increments after cycle T; the
  // snapshot is simply held until the ack cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset)     snap_q <= '0;
    else if (accept) snap_q <= rd_mux;
  end

  // Handshake state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Handshake sequencing: accept -> capture -> ack -> idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (perf_stb) state_d = S_CAPT;
      S_CAPT:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decoded from the registered state.
  always_comb begin
    perf_stall = (state_q != S_IDLE);
    perf_ack   = (state_q == S_ACK);
    perf_data  = perf_ack ? snap_q : '0;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank with a counter-level reference model.
module tb_perf_counter_bank;

  localparam int unsigned NCOUNT = 8;
  localparam int unsigned CW     = 8;
  localparam logic [7:0]  TIM_OK = 8'h59;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCOUNT-1:0] events = '0;
  logic              clr = 1'b0;
  logic              stb = 1'b0;
  logic [7:0]        addr = '0;
  logic              stall, ack;
  logic [31:0]       data;

  int n_checks = 0;
  int n_fail   = 0;

  longint unsigned mev [NCOUNT];
  logic [63:0]     mcyc;
  logic [31:0]     mshadow;

  perf_counter_bank #(.NCOUNT(NCOUNT), .CW(CW), .ENABLE_PERF(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_events(events), .i_clear(clr),
    .perf_stb(stb), .perf_addr(addr), .perf_stall(stall), .perf_ack(ack),
    .perf_data(data)
  );

  always #5 clk = ~clk;

  // One clock: model follows the inputs held across the rising edge.
  task automatic step();
    @(posedge clk);
    if (rst || clr) begin
      for (int k = 0; k < NCOUNT; k++) mev[k] = 0;
      mcyc = 64'd0;
      if (rst) mshadow = 32'd0;
    end else begin
      for (int k = 0; k < NCOUNT; k++)
        if (events[k]) mev[k] = (mev[k] + 1) % (64'd1 << CW);
      mcyc = mcyc + 64'd1;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (a < NCOUNT)  return 32'(mev[a]);
    if (a == 8'h40)  return mcyc[31:0];
    if (a == 8'h41)  return mshadow;
    if (a == 8'h42)  return 32'h5043_0000 | (NCOUNT << 8) | CW;
    return 32'd0;
  endfunction

  // Issue one read; returns observed data, model expectation and a timing signature.
  task automatic read_txn(input logic [7:0] a, input bit rnd_ev,
                          output logic [31:0] got, output logic [31:0] exp,
                          output logic [7:0] tim);
    stb  = 1'b1;
    addr = a;
    if (rnd_ev) events = NCOUNT'($urandom);
    tim[7] = stall;
    exp = model_read(a);
    if (a == 8'h40) mshadow = mcyc[63:32];
    step();
    stb = 1'b0;
    addr = 8'($urandom);
    if (rnd_ev) events = NCOUNT'($urandom);
    tim[6] = stall; tim[5] = ack;
    step();
    if (rnd_ev) events = NCOUNT'($urandom);
    tim[4] = stall; tim[3] = ack; got = data;
    step();
    events = '0;
    tim[2] = stall; tim[1] = ack; tim[0] = (data == 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({stall, ack, data} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b ack=%b data=%h, want 0/0/0", stall, ack, data);
    end
  endtask

  task automatic test_event_count();
    logic [31:0] got, exp; logic [7:0] tim;
    for (int i = 0; i < 5; i++) begin events = 8'h08; step(); end
    events = '0;
    read_txn(8'h03, 1'b0, got, exp, tim);
    n_checks++;
    if (tim !== TIM_OK) begin n_fail++; $display("FAIL ev3_timing: sig=%b want %b", tim, TIM_OK); end
    n_checks++;
    if (got !== 32'd5) begin n_fail++; $display("FAIL ev3_data: got %0d want 5", got); end
  endtask

  task automatic test_wrap();
    logic [31:0] got, exp; logic [7:0] tim;
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 260; i++) begin events = 8'h01; step(); end
    events = '0;
    read_txn(8'h00, 1'b0, got, exp, tim);
    n_checks++;
    if (got !== 32'd4 || exp !== 32'd4) begin
      n_fail++; $display("FAIL wrap: got %0d model %0d want 4", got, exp);
    end
  endtask

  task automatic test_clear_priority();
    logic [31:0] got, exp; logic [7:0] tim;
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 7; i++) begin events = 8'h02; step(); end
    events = '0;
    read_txn(8'h01, 1'b0, got, exp, tim);
    n_checks++;
    if (got !== 32'd7) begin n_fail++; $display("FAIL pre_clear: got %0d want 7", got); end
    clr = 1'b1; events = 8'h02; step(); clr = 1'b0; events = '0;
    read_txn(8'h01, 1'b0, got, exp, tim);
    n_checks++;
    if (got !== 32'd0) begin n_fail++; $display("FAIL clear_beats_event: got %0d want 0", got); end
  endtask

  task automatic test_cycle_hi();
    logic [31:0] got, exp; logic [7:0] tim;
    force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFA;
    #1;
    release dut.cyc_cnt;
    mcyc = 64'h0000_0000_FFFF_FFFA;
    read_txn(8'h40, 1'b0, got, exp, tim);
    n_checks++;
    if (got !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL cyc_lo: got %h want fffffffa", got); end
    for (int i = 0; i < 10; i++) step();
    read_txn(8'h41, 1'b0, got, exp, tim);
    n_checks++;
    if (got !== 32'd0) begin n_fail++; $display("FAIL cyc_hi_coherent: got %h want 0", got); end
    read_txn(8'h40, 1'b0, got, exp, tim);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL cyc_lo_after_carry: got %h want %h", got, exp); end
    read_txn(8'h41, 1'b0, got, exp, tim);
    n_checks++;
    if (got !== 32'd1) begin n_fail++; $display("FAIL cyc_hi_after_carry: got %h want 1", got); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    logic [33:0] want;
    stb = 1'b1; addr = 8'h77;
    for (int i = 0; i < 12; i++) begin
      want = {(i % 3) != 0, (i % 3) == 2, 32'd0};
      n_checks++;
      if ({stall, ack, data} !== want) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: stall=%b ack=%b data=%h want stall=%b ack=%b data=0",
                 i, stall, ack, data, want[33], want[32]);
      end
      if (ack) acks++;
      step();
    end
    stb = 1'b0;
    n_checks++;
    if (acks != 4) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 4", acks); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] got, exp; logic [7:0] tim;
    stb = 1'b1; addr = 8'h02;
    step();
    stb = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (stall !== 1'b0 || ack !== 1'b0) begin
        n_fail++; $display("FAIL midop_reset_cycle%0d: stall=%b ack=%b want 0/0", i, stall, ack);
      end
      step();
    end
    read_txn(8'h42, 1'b0, got, exp, tim);
    n_checks++;
    if (tim !== TIM_OK || got !== 32'h5043_0808) begin
      n_fail++; $display("FAIL post_reset_id: sig=%b data=%h want %b / 50430808", tim, got, TIM_OK);
    end
  endtask

  task automatic test_random();
    logic [31:0] got, exp; logic [7:0] tim;
    logic [7:0] a;
    logic [7:0] pick [12] = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h07, 8'h08,
                              8'h40, 8'h41, 8'h42, 8'h43, 8'h3F, 8'hFF};
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < int'($urandom_range(1, 20)); c++) begin
        events = NCOUNT'($urandom);
        clr = ($urandom_range(0, 15) == 0);
        step();
      end
      events = '0; clr = 1'b0;
      a = pick[$urandom_range(0, 11)];
      read_txn(a, 1'b1, got, exp, tim);
      n_checks++;
      if (got !== exp || tim !== TIM_OK) begin
        n_fail++;
        $display("FAIL rand_read%0d addr=%h: data=%h sig=%b want %h / %b", r, a, got, tim, exp, TIM_OK);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NCOUNT; k++) mev[k] = 0;
    mcyc = 64'd0;
    mshadow = 32'd0;
    @(negedge clk);
    test_reset();
    test_event_count();
    test_wrap();
    test_clear_priority();
    test_cycle_hi();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
